// File: rtl/hdlc_rx_drain_ctrl.sv
// HDLC receive drain sequencer: polls the core's Rx status, reads each frame
// out of Rx_Buff onto a valid/ready byte stream and drops bad frames.
module hdlc_rx_drain_ctrl #(
    parameter int POLL_INTERVAL = 16,
    parameter int READ_LATENCY  = 1,
    parameter int MAX_LEN       = 126
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       En,
    output logic [2:0] Address,
    output logic       WriteEnable,
    output logic       ReadEnable,
    output logic [7:0] DataIn,
    input  logic [7:0] DataOut,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_INTERVAL - 1);
    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] ADDR_SC   = 3'd2;
    localparam logic [2:0] ADDR_BUFF = 3'd3;
    localparam logic [2:0] ADDR_LEN  = 3'd4;
    localparam logic [7:0] DROP_CMD  = 8'h02;

    localparam logic [1:0] ERR_FRAME = 2'd1;
    localparam logic [1:0] ERR_OVF   = 2'd2;
    localparam logic [1:0] ERR_LEN   = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_POLL,
        S_POLL_WAIT,
        S_LEN,
        S_LEN_WAIT,
        S_RD,
        S_RD_WAIT,
        S_OUT,
        S_DROP
    } state_t;

    state_t state, stateNext;

    logic [PW-1:0] pollCnt, pollCntNext;
    logic [1:0]    latCnt, latCntNext;
    logic [7:0]    byteCnt, byteCntNext;
    logic [7:0]    frameLen, frameLenNext;
    logic [7:0]    mData, mDataNext;
    logic          mLast, mLastNext;
    logic          frameDone, frameDoneNext;
    logic [1:0]    errCode, errCodeNext;

    logic latDone;
    logic stReady;
    logic stErr;
    logic stOvf;
    logic lenBad;

    // Read data is only meaningful in the last wait cycle of an access.
    assign latDone = (latCnt == LAT_LAST);
    assign stReady = DataOut[0];
    assign stErr   = DataOut[2] | DataOut[3];
    assign stOvf   = DataOut[4];
    assign lenBad  = (DataOut == 8'd0) || (DataOut > MAX_LEN_B);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= S_IDLE;
            pollCnt   <= '0;
            latCnt    <= '0;
            byteCnt   <= '0;
            frameLen  <= '0;
            mData     <= '0;
            mLast     <= 1'b0;
            frameDone <= 1'b0;
            errCode   <= '0;
        end else begin
            state     <= stateNext;
            pollCnt   <= pollCntNext;
            latCnt    <= latCntNext;
            byteCnt   <= byteCntNext;
            frameLen  <= frameLenNext;
            mData     <= mDataNext;
            mLast     <= mLastNext;
            frameDone <= frameDoneNext;
            errCode   <= errCodeNext;
        end
    end

    always_comb begin
        stateNext     = state;
        pollCntNext   = pollCnt;
        latCntNext    = latCnt;
        byteCntNext   = byteCnt;
        frameLenNext  = frameLen;
        mDataNext     = mData;
        mLastNext     = mLast;
        frameDoneNext = 1'b0;
        errCodeNext   = errCode;
        Address       = 3'd0;
        WriteEnable   = 1'b0;
        ReadEnable    = 1'b0;
        DataIn        = 8'd0;

        unique case (state)
            S_IDLE: begin
                if (En) begin
                    if (pollCnt == POLL_LAST) begin
                        pollCntNext = '0;
                        stateNext   = S_POLL;
                    end else begin
                        pollCntNext = pollCnt + PW'(1);
                    end
                end
            end

            S_POLL: begin
                Address    = ADDR_SC;
                ReadEnable = 1'b1;
                latCntNext = '0;
                stateNext  = S_POLL_WAIT;
            end

            S_POLL_WAIT: begin
                Address = ADDR_SC;
                if (!latDone) begin
                    latCntNext = latCnt + 2'd1;
                end else begin
                    // Overflow outranks frame error / abort.
                    unique case (1'b1)
                        !stReady: stateNext = S_IDLE;
                        stReady && stOvf: begin
                            errCodeNext = ERR_OVF;
                            stateNext   = S_DROP;
                        end
                        stReady && !stOvf && stErr: begin
                            errCodeNext = ERR_FRAME;
                            stateNext   = S_DROP;
                        end
                        stReady && !stOvf && !stErr: begin
                            stateNext = S_LEN;
                        end
                        default: stateNext = S_IDLE;
                    endcase
                end
            end

            S_LEN: begin
                Address    = ADDR_LEN;
                ReadEnable = 1'b1;
                latCntNext = '0;
                stateNext  = S_LEN_WAIT;
            end

            S_LEN_WAIT: begin
                Address = ADDR_LEN;
                if (!latDone) begin
                    latCntNext = latCnt + 2'd1;
                end else if (lenBad) begin
                    errCodeNext = ERR_LEN;
                    stateNext   = S_DROP;
                end else begin
                    frameLenNext = DataOut;
                    byteCntNext  = 8'd0;
                    stateNext    = S_RD;
                end
            end

            S_RD: begin
                Address    = ADDR_BUFF;
                ReadEnable = 1'b1;
                latCntNext = '0;
                stateNext  = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                Address = ADDR_BUFF;
                if (!latDone) begin
                    latCntNext = latCnt + 2'd1;
                end else begin
                    mDataNext = DataOut;
                    mLastNext = (byteCnt == frameLen - 8'd1);
                    stateNext = S_OUT;
                end
            end

            S_OUT: begin
                if (m_ready) begin
                    byteCntNext = byteCnt + 8'd1;
                    if (mLast) begin
                        frameDoneNext = 1'b1;
                        stateNext     = S_IDLE;
                    end else begin
                        stateNext = S_RD;
                    end
                end
            end

            S_DROP: begin
                Address     = ADDR_SC;
                WriteEnable = 1'b1;
                DataIn      = DROP_CMD;
                stateNext   = S_IDLE;
            end

            default: stateNext = S_IDLE;
        endcase
    end

    assign m_data     = mData;
    assign m_valid    = (state == S_OUT);
    assign m_last     = mLast && (state == S_OUT);
    assign frame_done = frameDone;
    assign frame_err  = (state == S_DROP);
    assign err_code   = errCode;
    assign busy       = (state != S_IDLE);

endmodule
